pwm_channel_bank: RTL
=====================

// Module: pwm_channel_bank
// PURPOSE
//  Eight-channel PWM waveform generator inside the Timer peripheral; one instance per PWM group (A..D).
//  Consumes the per-channel compare words written over Wishbone and drives one PWM pin level per channel.
//  Each channel has its own period/duty counter, clocked by a shared prescaled tick.
//  Pin levels go to the GPIO pin mux; wrap pulses go to the interrupt logic.
// PARAMETERS
//  CH     8   number of channels (1..8)
//  PRESC  50  clk_i cycles per counter tick (>=1); 50 gives a 1 us tick at 50 MHz
// PORTS
//  clk_i      in   1       system clock, all logic on posedge
//  rst_i      in   1       reset; asynchronous, active-high
//  cmp_i      in   CH*32   compare words; channel k = cmp_i[32k+31:32k]; [31:16]=period P, [15:0]=duty D
//  pwm_o      out  CH      registered PWM pin levels
//  wrap_o     out  CH      one-clk pulse per channel at end of each period
// BEHAVIOUR
//  - Reset (async assert): presc_cnt=0, all cnt_k=0, all shadow P/D=0, pwm_o=0, wrap_o=0.
//    Release is synchronous to clk_i. First tick occurs PRESC clks after release.
//  - Prescaler: presc_cnt counts 0..PRESC-1. tick=1 in the cycle presc_cnt==PRESC-1, then presc_cnt wraps to 0.
//    PRESC=1: tick every clk.
//  - Per channel k, using effective Pe/De (see CONFIGURATION), on a tick cycle:
//    * Pe==0: channel disabled; cnt_k<=0; no wrap.
//    * cnt_k >= Pe-1: cnt_k<=0; wrap_o[k]<=1 on next edge, for exactly 1 clk. Use >=, not ==, so a shrunken period never runs to 65535.
//    * otherwise: cnt_k<=cnt_k+1.
//    Non-tick cycles: cnt_k holds; wrap_o[k]<=0.
//  - Output, every clk: pwm_o[k] <= (Pe!=0) && (cnt_k < De). This gives 1 clk latency from counter state to pin.
//    Boundaries: De==0 -> pin constantly low. De>=Pe (Pe!=0) -> pin constantly high.
//    Pe==0 -> pin low regardless of De.
//  - Resulting waveform: high for De ticks, then low for Pe-De ticks; period Pe*PRESC clks.
//  - Arithmetic: cnt_k is 16 bits unsigned; Pe-1 is computed only when Pe!=0, so there is no underflow.
//  - Channels are fully independent; simultaneous wraps on several channels assert several wrap_o bits in the same cycle.
//  - Reset mid-period: cnt, shadows and outputs clear immediately; counting restarts from 0 after release.
// CONFIGURATION
//  Macro PWM_SHADOW_EN.
//  - Defined: per-channel shadow registers {Ps,Ds} (32 bits) with Pe=Ps and De=Ds.
//    Shadow loads from cmp_i word k in two cases:
//      (a) on the tick that wraps channel k;
//      (b) on every tick while Ps==0, so a disabled channel picks up a new setting on the next tick.
//    Mid-period writes therefore take effect glitch-free at the period boundary.
//  - Not defined: no shadow registers; Pe/De come directly from cmp_i, so changes take effect next clk.
//    If the new P <= cnt_k, the channel wraps on the next tick (the >= rule).
// TESTING
//  1. PRESC=1, ch0 P=10 D=3 -> pwm_o[0] high 3 clks, low 7 clks, repeating; wrap_o[0] 1-clk pulse every 10 clks.
//  2. ch1 D=0 P=10 -> pwm_o[1] stays 0. ch2 D=12 P=10 -> pwm_o[2] stays 1. ch3 P=0 D=5 -> pwm_o[3]=0 and wrap_o[3] never pulses.
//  3. PRESC=4, P=5 D=2 -> high 8 clks, low 12 clks; wrap_o spacing 20 clks; all 8 channels checked concurrently.
//  4. PWM_SHADOW_EN defined: at cnt=6 of P=10 D=3, write P=4 D=1 -> the current period finishes at 10 ticks, then high 1 / low 3.
//  5. PWM_SHADOW_EN undefined: same write at cnt=6 -> wrap on the next tick (6>=3), then high 1 / low 3; no cnt overflow.
//  6. Assert rst_i asynchronously between clock edges mid-period -> pwm_o and wrap_o go 0 immediately.
//     After release, the first rising pwm edge comes PRESC+1 clks later and the waveform repeats scenario 1 exactly.

Source files
------------

// File: rtl/pwm_channel_bank.sv
// pwm_channel_bank: eight-channel PWM generator for one Timer PWM group.
// Every channel has its own period/duty counter. All channel counters advance
// on a shared prescaled tick. Pin levels go to the GPIO mux, and wrap pulses go
// to the interrupt logic.
// Optional feature macro: PWM_SHADOW_EN. When it is defined, each channel
// latches its compare word into a shadow register at the period boundary.
// When it is not defined, the compare words act directly.
`timescale 1ns/1ps

module pwm_channel_bank #(
   parameter int CH    = 8,
   parameter int PRESC = 50
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CH*32-1:0]  cmp_i,
   output logic [CH-1:0]     pwm_o,
   output logic [CH-1:0]     wrap_o
);

   localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

   logic [PW-1:0] presc_cnt_q, presc_cnt_d;
   logic          tick;

   logic [15:0]   cnt_q [CH];
   logic [15:0]   cnt_d [CH];
   logic [15:0]   pe    [CH];
   logic [15:0]   de    [CH];
   logic [CH-1:0] pwm_q, pwm_d;
   logic [CH-1:0] wrap_q, wrap_d;

`ifdef PWM_SHADOW_EN
   logic [31:0]   shd_q [CH];
   logic [31:0]   shd_d [CH];
`endif

   // Prescaler: tick is high in the last cycle of each PRESC-clock window.
   always_comb begin
      tick        = (presc_cnt_q == PRESC_LAST);
      presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
   end

   // Per-channel counter, wrap and pin-level next state.
   always_comb begin
      for (int k = 0; k < CH; k++) begin
         cnt_d[k]  = cnt_q[k];
         wrap_d[k] = 1'b0;
`ifdef PWM_SHADOW_EN
         shd_d[k]  = shd_q[k];
         pe[k]     = shd_q[k][31:16];
         de[k]     = shd_q[k][15:0];
`else
         pe[k]     = cmp_i[32*k+16 +: 16];
         de[k]     = cmp_i[32*k    +: 16];
`endif
         if (tick) begin
            if (pe[k] == 16'd0) begin
               // A disabled channel parks at 0 and, with shadowing, keeps
               // sampling the compare word so a new setting starts next tick.
               cnt_d[k] = 16'd0;
`ifdef PWM_SHADOW_EN
               shd_d[k] = cmp_i[32*k +: 32];
`endif
            end else if (cnt_q[k] >= pe[k] - 16'd1) begin
               // >= so that a period shrunk below the count wraps at once.
               cnt_d[k]  = 16'd0;
               wrap_d[k] = 1'b1;
`ifdef PWM_SHADOW_EN
               shd_d[k]  = cmp_i[32*k +: 32];
`endif
            end else begin
               cnt_d[k] = cnt_q[k] + 16'd1;
            end
         end
         pwm_d[k] = (pe[k] != 16'd0) && (cnt_q[k] < de[k]);
      end
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         presc_cnt_q <= '0;
         pwm_q       <= '0;
         wrap_q      <= '0;
         for (int k = 0; k < CH; k++) begin
            cnt_q[k] <= 16'd0;
`ifdef PWM_SHADOW_EN
            shd_q[k] <= 32'd0;
`endif
         end
      end else begin
         presc_cnt_q <= presc_cnt_d;
         pwm_q       <= pwm_d;
         wrap_q      <= wrap_d;
         for (int k = 0; k < CH; k++) begin
            cnt_q[k] <= cnt_d[k];
`ifdef PWM_SHADOW_EN
            shd_q[k] <= shd_d[k];
`endif
         end
      end
   end

   assign pwm_o  = pwm_q;
   assign wrap_o = wrap_q;

endmodule
